// File: rtl/alu_execute_unit.sv
// alu_execute_unit: execute-stage ALU with one-cycle logic/arithmetic ops and
// an iterative shift-add multiplier that holds off the front of the pipe
// through a valid/ready handshake while it runs.
module alu_execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Alucontrol,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ovf;
  logic [WIDTH-1:0]  acc_step;

  // Ready depends only on state and reset so the hazard unit never sees a loop through in_valid.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Overflow  = overflow_q;

  // Single-cycle datapath: all one-cycle opcodes plus signed overflow for ADD/SUB.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (Alucontrol)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: alu_res = ~(A | B);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // One shift-add iteration: the accumulator picks up the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and output logic; flush abandons any multiply and blocks acceptance this cycle.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (Alucontrol == OP_MUL) begin
              state_d  = ST_MUL;
              mcand_d  = A;
              mplier_d = B;
              acc_d    = '0;
              count_d  = '0;
            end else begin
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              overflow_d  = alu_ovf;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            result_d    = acc_step;
            zero_d      = (acc_step == '0);
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
            count_d     = '0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous reset, which overrides flush and any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: scenario tasks with randomized operands, checked
// against an arithmetic reference model of the ALU opcodes.
module tb_alu_execute_unit;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_ctl;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              out_valid;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  alu_execute_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Alucontrol (alu_ctl),
    .A          (a_in),
    .B          (b_in),
    .out_valid  (out_valid),
    .Result     (result),
    .Zero       (zero),
    .Overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: opcode semantics from plain integer arithmetic.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf);
    longint sa;
    longint sb;
    longint s;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 32'h0;
    ovf = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s   = sa + sb;
        r   = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s   = sa - sb;
        r   = s[31:0];
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1000: begin
        p = {32'h0, a} * {32'h0, b};
        r = p[31:0];
      end
      default: r = 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctl  = op;
    a_in     = a;
    b_in     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int stray;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_ctl = 4'h0; a_in = '0; b_in = '0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_low: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state: got v=%b r=%h z=%b o=%b rdy=%b expected v=0 r=0 z=1 o=0 rdy=1",
               out_valid, result, zero, overflow, in_ready);
    end
    // Abort a multiply midway with a two-cycle reset.
    do_op(4'b1000, 32'h00012345, 32'h00000100);
    repeat (5) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul: got v=%b r=%h z=%b rdy=%b expected v=0 r=0 z=1 rdy=1",
               out_valid, result, zero, in_ready);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin failures++; $display("[TB] FAIL reset_mul_aborted: got %0d pulses expected 0", stray); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [6];
    logic [31:0] exp [6];
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    exp = '{32'h12, 32'hC, 32'h3, 32'hF, 32'hFFFFFFF0, 32'h0};
    in_valid = 1'b1; a_in = 32'h0000000F; b_in = 32'h00000003;
    for (int i = 0; i < 6; i++) begin
      alu_ctl = ops[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL alu_ready_%0d: got %b expected 1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== exp[i]) begin
        failures++;
        $display("[TB] FAIL alu_op_%0d: got v=%b r=%h expected v=1 r=%h", i, out_valid, result, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL alu_pulse_end: got %b expected 0", out_valid); end
    do_op(4'b0111, 32'hFFFFFFFF, 32'h00000001);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h1 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL slt_signed: got v=%b r=%h z=%b expected v=1 r=1 z=0", out_valid, result, zero);
    end
  endtask

  task automatic test_overflow_zero();
    do_op(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    checks++;
    if (result !== 32'h80000000 || overflow !== 1'b1 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL add_overflow: got r=%h o=%b z=%b expected r=80000000 o=1 z=0", result, overflow, zero);
    end
    do_op(4'b0110, 32'd5, 32'd5);
    checks++;
    if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sub_zero: got r=%h z=%b o=%b expected r=0 z=1 o=0", result, zero, overflow);
    end
    do_op(4'b0010, 32'h1, 32'h1);
    do_op(4'b1111, 32'h1234, 32'h5678);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL undefined_op: got v=%b r=%h z=%b o=%b expected v=1 r=0 z=1 o=0", out_valid, result, zero, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        eo;
    logic [31:0] edge_vals [4];
    edge_vals = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'b1000) op = 4'b0110;
      a = (($urandom & 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b = (($urandom & 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      ref_alu(op, a, b, er, eo);
      in_valid = 1'b1; alu_ctl = op; a_in = a; b_in = b;
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== er || zero !== (er == 32'h0) || overflow !== eo) begin
        failures++;
        $display("[TB] FAIL b2b_%0d op=%h a=%h b=%h: got v=%b r=%h z=%b o=%b expected v=1 r=%h z=%b o=%b",
                 i, op, a, b, out_valid, result, zero, overflow, er, (er == 32'h0), eo);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul();
    logic [31:0] ma [5];
    logic [31:0] mb [5];
    logic [31:0] er;
    logic        eo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    int busy_bad;
    ma = '{32'h00012345, 32'hFFFFFFFF, $urandom, $urandom, 32'h00010001};
    mb = '{32'h00000100, 32'hFFFFFFFF, $urandom, $urandom & 32'h0000FFFF, 32'h00000000};
    for (int c = 0; c < 5; c++) begin
      ref_alu(4'b1000, ma[c], mb[c], er, eo);
      if (c == 0) er = 32'h01234500;
      if (c == 1) er = 32'h00000001;
      do_op(4'b1000, ma[c], mb[c]);
      // Keep an ADD pending throughout; it must wait for in_ready.
      add_a = $urandom & 32'h0FFFFFFF;
      add_b = $urandom & 32'h0FFFFFFF;
      in_valid = 1'b1; alu_ctl = 4'b0010; a_in = add_a; b_in = add_b;
      busy_bad = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
        step();
      end
      checks++;
      if (busy_bad != 0) begin failures++; $display("[TB] FAIL mul_busy_%0d: got %0d bad cycles expected 0", c, busy_bad); end
      checks++;
      if (out_valid !== 1'b1 || result !== er || zero !== (er == 32'h0) || overflow !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL mul_result_%0d: got v=%b r=%h z=%b o=%b rdy=%b expected v=1 r=%h z=%b o=0 rdy=1",
                 c, out_valid, result, zero, overflow, in_ready, er, (er == 32'h0));
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== add_a + add_b) begin
        failures++;
        $display("[TB] FAIL mul_then_add_%0d: got v=%b r=%h expected v=1 r=%h", c, out_valid, result, add_a + add_b);
      end
      in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_flush();
    int stray;
    do_op(4'b0010, 32'h70, 32'h7);
    do_op(4'b1000, $urandom | 32'h1, $urandom | 32'h1);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h77 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_mid_mul: got v=%b r=%h rdy=%b expected v=0 r=77 rdy=1", out_valid, result, in_ready);
    end
    stray = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (out_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0 || result !== 32'h77) begin
      failures++;
      $display("[TB] FAIL flush_discard: got %0d pulses r=%h expected 0 pulses r=77", stray, result);
    end
    do_op(4'b0010, 32'd2, 32'd2);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h4) begin
      failures++;
      $display("[TB] FAIL flush_then_add: got v=%b r=%h expected v=1 r=4", out_valid, result);
    end
  endtask

  task automatic test_rst_flush();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; alu_ctl = 4'b0010; a_in = 32'h1; b_in = 32'h1;
    step();
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_flush_edge: got v=%b r=%h z=%b o=%b rdy=%b expected v=0 r=0 z=1 o=0 rdy=0",
               out_valid, result, zero, overflow, in_ready);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_flush_after: got v=%b r=%h rdy=%b expected v=0 r=0 rdy=1", out_valid, result, in_ready);
    end
  endtask

  // Run the scenarios in order, then report.
  initial begin
    test_reset();
    test_alu_ops();
    test_overflow_zero();
    test_back_to_back();
    test_mul();
    test_flush();
    test_rst_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute-stage ALU for the pipelined CPU, sitting between the ID/EX and EX/MEM pipeline registers. It consumes the 4-bit ALU control code produced by ALU control decode, together with two 32-bit operands. Single-cycle operations return a registered result after one clock. MUL is computed iteratively over 32 cycles, and a valid/ready handshake lets the hazard unit stall the front of the pipeline while a multiply is in progress.

## Interface
Parameters:
- WIDTH, 32, operand/result width; MUL iteration count equals WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort from hazard/branch logic.
- in_valid  in  1  ID/EX presents an operation this cycle.
- in_ready  out  1  unit can accept an operation this cycle.
- Alucontrol  in  4  operation code from ALU control decode.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt or sign-extended immediate).
- out_valid  out  1  Result/Zero/Overflow valid; one-cycle pulse per accepted operation.
- Result  out  WIDTH  registered result.
- Zero  out  1  registered (Result == 0).
- Overflow  out  1  registered signed overflow; ADD/SUB only, 0 otherwise.

## Operation
- Accept occurs on a rising edge where in_valid=1, in_ready=1 and flush=0.
- in_ready = (state == IDLE) && !rst. Combinational from state only; it never depends on in_valid.
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD (A+B, wraps mod 2^WIDTH).
  - 0110 SUB (A-B, wraps).
  - 0111 SLT (signed A<B → 1, else 0).
  - 1100 NOR.
  - 1000 MUL: low WIDTH bits of the unsigned product. Signed and unsigned give identical low bits.
- Any other code → Result=0, Zero=1, Overflow=0, out_valid still pulses.
- Overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
- States:
  - IDLE: accept of a non-MUL op writes Result/Zero/Overflow and sets out_valid=1 at that edge. State stays IDLE.
  - IDLE → MUL on accept of 1000. At that edge, latch multiplicand=A, multiplier=B, acc=0, count=0. out_valid=0.
  - MUL: each edge, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - MUL exit: on the edge where count==WIDTH-1, write the final acc (including this iteration) to Result, set Zero and out_valid=1, Overflow=0, and return to IDLE.
- Result/Zero/Overflow hold their last value when out_valid=0.
- flush=1 at an edge: state→IDLE, out_valid=0, no accept that cycle, Result unchanged. A MUL in progress is discarded.
- Reset takes priority over flush.
- Reset at an edge: state=IDLE, count=0, acc=0, out_valid=0, Result=0, Zero=1, Overflow=0. A MUL in progress is aborted.

## Timing
- Non-MUL latency is 1: accepted at edge k, out_valid=1 during the cycle after edge k.
- Back-to-back non-MUL ops are accepted every cycle with out_valid continuously high, one result per cycle.
- MUL latency is WIDTH: accepted at edge k, result written at edge k+WIDTH. in_ready=0 for cycles after edge k through edge k+WIDTH.
- The cycle in which MUL out_valid=1 has in_ready=1, so a new op may be accepted at the next edge.
- out_valid is never high for two consecutive cycles from one accept.
- No combinational path from A/B/Alucontrol to any output.

## Test plan
- Reset: hold rst 2 cycles mid-MUL → out_valid=0, Result=0, Zero=1, in_ready=1 the cycle after release.
- ALU ops back-to-back with A=0x0000000F, B=0x00000003:
  - ADD → 0x12.
  - SUB → 0xC.
  - AND → 0x3.
  - OR → 0xF.
  - NOR → 0xFFFFFFF0.
  - SLT → 0.
  - Each with out_valid=1 exactly one cycle after its accept.
  - SLT with A=0xFFFFFFFF, B=1 → 1.
- Overflow/Zero:
  - ADD 0x7FFFFFFF+1 → Result 0x80000000, Overflow=1.
  - SUB 5-5 → Result 0, Zero=1, Overflow=0.
  - Code 1111 → Result 0, Zero=1, out_valid pulses.
- MUL:
  - A=0x00012345, B=0x00000100 → Result 0x01234500 exactly 32 edges after accept; in_ready low for 32 cycles.
  - A=0xFFFFFFFF, B=0xFFFFFFFF → 0x00000001.
  - An in_valid asserted during MUL is not accepted until in_ready rises.
- Flush mid-MUL at iteration 10 → no out_valid, Result keeps previous value, in_ready=1 next cycle; a following ADD 2+2 yields 4.
- Simultaneous rst and flush plus in_valid at the same edge → reset values, nothing accepted.
